// File: rtl/lstx_fifo_if.sv
// Host-side and serialiser-side signal bundle for lstx_fifo.
// master drives host controls and the lstx empty status; slave is the FIFO.
interface lstx_fifo_if #(
  parameter int DMSB = 9,
  parameter int AMSB = 3
);
  logic                 setn;
  logic                 wr;
  logic signed [DMSB:0] din;
  logic                 clear;
  logic                 full;
  logic                 fempty;
  logic [AMSB+1:0]      count;
  logic                 ovf;
  logic                 werr;
  logic                 busy;
  logic [1:0]           st;
  logic                 tx_empty;
  logic                 tx_push;
  logic signed [DMSB:0] tx_wdata;

  modport master (
    output setn, wr, din, clear, tx_empty,
    input  full, fempty, count, ovf, werr, busy, st, tx_push, tx_wdata
  );

  modport slave (
    input  setn, wr, din, clear, tx_empty,
    output full, fempty, count, ovf, werr, busy, st, tx_push, tx_wdata
  );
endinterface

// File: rtl/lstx_fifo.sv
// Circular transmit FIFO feeding the lstx serialiser one word at a time via a toggle push.
// Optional BUSY-state watchdog enabled by defining LSTX_FIFO_WDOG_EN.
module lstx_fifo #(
  parameter int DMSB = 9,
  parameter int AMSB = 3
) (
  input logic        clk,
  input logic        rst,
  lstx_fifo_if.slave bus
);
  localparam int DEPTH = 2 ** (AMSB + 1);
  localparam logic [AMSB+1:0] DEPTH_C = {1'b1, {(AMSB + 1){1'b0}}};
  localparam logic [AMSB:0]   PTR_ONE = (AMSB + 1)'(1);
  localparam logic [AMSB+1:0] CNT_ONE = (AMSB + 2)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e               st_q, st_d;
  logic [AMSB:0]        wptr_q, wptr_d;
  logic [AMSB:0]        rptr_q, rptr_d;
  logic [AMSB+1:0]      count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 werr_q, werr_d;
  logic                 push_q, push_d;
  logic signed [DMSB:0] wdata_q, wdata_d;
  logic signed [DMSB:0] mem [DEPTH];

  logic full;
  logic launch;
  logic do_wr;
  logic wd_expire;

  assign full   = (count_q == DEPTH_C);
  // Pop decision uses the registered count, so a same-cycle write is never popped.
  assign launch = (st_q == IDLE) && (count_q != '0) && bus.tx_empty && !bus.clear;
  assign do_wr  = bus.wr && !full && !bus.clear;

`ifdef LSTX_FIFO_WDOG_EN
  logic [3:0] wd_q, wd_d;

  assign wd_expire = (st_q == BUSY) && bus.tx_empty && (wd_q == 4'd14);

  always_comb begin
    wd_d = wd_q;
    if (launch) begin
      wd_d = '0;
    end else if (st_q == BUSY) begin
      wd_d = wd_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q <= '0;
    end else if (bus.setn) begin
      wd_q <= wd_d;
    end
  end
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    st_d    = st_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    werr_d  = werr_q;
    push_d  = push_q;
    wdata_d = wdata_q;

    unique case (st_q)
      IDLE: if (launch) st_d = BUSY;
      BUSY: begin
        if (!bus.tx_empty) begin
          st_d = DONE;
        end else if (wd_expire) begin
          st_d = IDLE;
        end
      end
      DONE: if (bus.tx_empty) st_d = IDLE;
      default: st_d = IDLE;
    endcase

    if (launch) begin
      wdata_d = mem[rptr_q];
      push_d  = ~push_q;
    end

    if (bus.clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      werr_d  = 1'b0;
    end else begin
      if (do_wr)  wptr_d = wptr_q + PTR_ONE;
      if (launch) rptr_d = rptr_q + PTR_ONE;
      unique case ({do_wr, launch})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      if (bus.wr && full) ovf_d  = 1'b1;
      if (wd_expire)      werr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      werr_q  <= 1'b0;
      push_q  <= 1'b0;
      wdata_q <= '0;
    end else if (bus.setn) begin
      st_q    <= st_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      werr_q  <= werr_d;
      push_q  <= push_d;
      wdata_q <= wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.setn && do_wr) begin
      mem[wptr_q] <= bus.din;
    end
  end

  assign bus.full     = full;
  assign bus.fempty   = (count_q == '0);
  assign bus.count    = count_q;
  assign bus.ovf      = ovf_q;
  assign bus.werr     = werr_q;
  assign bus.busy     = (st_q != IDLE);
  assign bus.st       = st_q;
  assign bus.tx_push  = push_q;
  assign bus.tx_wdata = wdata_q;
endmodule

// File: tb/tb_lstx_fifo.sv
// Self-checking bench for lstx_fifo: queue-based reference model, a small lstx responder,
// directed scenarios and a randomized run.
module tb_lstx_fifo;
  localparam int DMSB  = 9;
  localparam int AMSB  = 3;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lstx_fifo_if #(.DMSB(DMSB), .AMSB(AMSB)) bus ();
  lstx_fifo #(.DMSB(DMSB), .AMSB(AMSB)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic signed [DMSB:0] m_q[$];
  logic signed [DMSB:0] launched[$];
  logic signed [DMSB:0] m_wdata = '0;
  bit m_ovf = 0, m_werr = 0, m_push = 0;
  int m_st = 0, m_wd = 0;

  // lstx responder: mode 0 normal, 1 forced busy, 2 never reacts
  int lx_mode = 0, lx_react = 0, lx_frame = 0, lx_flen = 6;
  bit lx_last = 0;
  int toggles = 0;
  logic signed [DMSB:0] rx_log[$];

  task automatic chk(string name, logic signed [31:0] act, logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin : model
    bit full_b, launch, to_werr;
    int nst;
    if (rst) begin
      m_q.delete();
      launched.delete();
      m_ovf = 0; m_werr = 0; m_push = 0; m_st = 0; m_wd = 0; m_wdata = '0;
    end else if (bus.setn) begin
      full_b  = (m_q.size() == DEPTH);
      launch  = (m_st == 0) && (m_q.size() != 0) && (bus.tx_empty === 1'b1) && !bus.clear;
      to_werr = 0;
      nst     = m_st;
      if (m_st == 0) begin
        if (launch) nst = 1;
      end else if (m_st == 1) begin
        if (!bus.tx_empty) nst = 2;
`ifdef LSTX_FIFO_WDOG_EN
        else if (m_wd == 14) begin nst = 0; to_werr = 1; end
`endif
      end else if (bus.tx_empty) begin
        nst = 0;
      end
      if (launch) m_wd = 0;
      else if (m_st == 1) m_wd = (m_wd + 1) % 16;
      if (launch) begin
        m_wdata = m_q.pop_front();
        m_push  = !m_push;
        launched.push_back(m_wdata);
      end
      if (bus.clear) begin
        m_q.delete();
        m_ovf  = 0;
        m_werr = 0;
      end else begin
        if (bus.wr) begin
          if (full_b) m_ovf = 1;
          else m_q.push_back(bus.din);
        end
        if (to_werr) m_werr = 1;
      end
      m_st = nst;
    end
  end

  always @(negedge clk) begin
    chk("count",    bus.count,    m_q.size());
    chk("full",     bus.full,     m_q.size() == DEPTH);
    chk("fempty",   bus.fempty,   m_q.size() == 0);
    chk("ovf",      bus.ovf,      m_ovf);
    chk("werr",     bus.werr,     m_werr);
    chk("st",       bus.st,       m_st);
    chk("busy",     bus.busy,     m_st != 0);
    chk("tx_push",  bus.tx_push,  m_push);
    chk("tx_wdata", bus.tx_wdata, m_wdata);
    if (!rst) begin
      if (lx_mode == 0) begin
        if (lx_frame > 0) begin
          lx_frame--;
        end else if (lx_react > 0) begin
          lx_react--;
          if (lx_react == 0) begin
            rx_log.push_back(bus.tx_wdata);
            if (launched.size() == 0) begin
              checks++; errors++;
              $display("FAIL rx_order: got word %0d expected no word", bus.tx_wdata);
            end else begin
              chk("rx_word", bus.tx_wdata, launched.pop_front());
            end
            lx_frame = lx_flen;
          end
        end else if (bus.tx_push !== lx_last) begin
          lx_last  = bus.tx_push;
          lx_react = 2;
          toggles++;
        end
      end else if (lx_mode == 2 && bus.tx_push !== lx_last) begin
        lx_last = bus.tx_push;
        toggles++;
        if (launched.size() != 0) void'(launched.pop_front());
      end
    end
    bus.tx_empty = (lx_mode == 1) ? 1'b0 : (lx_mode == 2) ? 1'b1 : (lx_frame == 0);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_mode(int m);
    lx_mode = m;
    bus.tx_empty = (m == 1) ? 1'b0 : (m == 2) ? 1'b1 : (lx_frame == 0);
  endtask

  task automatic wait_drain(string nm);
    int n = 0;
    while (!(m_q.size() == 0 && m_st == 0 && lx_frame == 0 && lx_react == 0) && n < 2000) begin
      tick();
      n++;
    end
    chk(nm, n < 2000, 1);
  endtask

  task automatic write_word(logic signed [DMSB:0] v);
    bus.wr  = 1'b1;
    bus.din = v;
    tick();
    bus.wr  = 1'b0;
  endtask

  initial begin : stim
    int tog0, sz, n;
    bus.setn = 1'b1; bus.wr = 1'b0; bus.din = '0; bus.clear = 1'b0; bus.tx_empty = 1'b1;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_count", bus.count, 0);
    chk("rst_fempty", bus.fempty, 1);
    chk("rst_st", bus.st, 0);
    chk("rst_push", bus.tx_push, 0);

    // Single word: count after E0, launch at E1
    write_word(10'sh155);
    chk("t1_count_e0", bus.count, 1);
    chk("t1_push_e0", bus.tx_push, 0);
    tick();
    chk("t1_push_e1", bus.tx_push, 1);
    chk("t1_wdata_e1", bus.tx_wdata, 32'sh155);
    chk("t1_st_e1", bus.st, 1);
    wait_drain("t1_drain");

    // Fill to full, one extra write overflows, then drain in order
    rx_log.delete();
    tog0 = toggles;
    set_mode(1);
    for (int i = 0; i < 17; i++) write_word(10'(i));
    chk("t2_full", bus.full, 1);
    chk("t2_ovf", bus.ovf, 1);
    chk("t2_count", bus.count, 16);
    set_mode(0);
    wait_drain("t2_drain");
    chk("t2_toggles", toggles - tog0, 16);
    chk("t2_rx_size", rx_log.size(), 16);
    for (int i = 0; i < 16 && i < rx_log.size(); i++) chk("t2_rx_order", rx_log[i], i);

    // Bring pointers to 12, then write at 15 and launch in the same edge (wptr wraps)
    for (int i = 0; i < 11; i++) write_word(10'(96 + i));
    wait_drain("t3_prefill");
    set_mode(1);
    write_word(10'sh3A); write_word(10'sh3B); write_word(10'sh3C);
    bus.wr = 1'b1; bus.din = 10'sh3D;
    set_mode(0);
    tick();
    bus.wr = 1'b0;
    chk("t3_count", bus.count, 3);
    chk("t3_wdata", bus.tx_wdata, 32'sh3A);
    wait_drain("t3_drain");
    sz = rx_log.size();
    for (int i = 0; i < 4; i++) chk("t3_rx_tail", rx_log[sz - 4 + i], 32'sh3A + i);

    // Clear while DONE with 5 words queued
    lx_flen = 8;
    set_mode(1);
    for (int i = 0; i < 6; i++) write_word(10'(64 + i));
    set_mode(0);
    n = 0;
    while (bus.st !== 2'b10 && n < 20) begin tick(); n++; end
    chk("t4_reach_done", n < 20, 1);
    chk("t4_count_pre", bus.count, 5);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("t4_count", bus.count, 0);
    chk("t4_fempty", bus.fempty, 1);
    chk("t4_ovf_cleared", bus.ovf, 0);
    chk("t4_st_done", bus.st, 2);
    tog0 = toggles;
    wait_drain("t4_drain");
    repeat (10) tick();
    chk("t4_no_toggle", toggles - tog0, 0);
    chk("t4_st_idle", bus.st, 0);

    // Freeze mid-BUSY with wr toggling
    lx_flen = 20;
    write_word(-10'sd57);
    bus.wr = 1'b1; bus.din = 10'sh72;
    tick();
    chk("t5_st_busy", bus.st, 1);
    chk("t5_count", bus.count, 1);
    bus.setn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.wr  = (i % 2 == 0);
      bus.din = 10'($urandom_range(0, 1023));
      tick();
    end
    chk("t5_frz_st", bus.st, 1);
    chk("t5_frz_count", bus.count, 1);
    chk("t5_frz_wdata", bus.tx_wdata, -57);
    bus.setn = 1'b1;
    bus.wr = 1'b0;
    wait_drain("t5_drain");
    sz = rx_log.size();
    chk("t5_rx_a", rx_log[sz - 2], -57);
    chk("t5_rx_b", rx_log[sz - 1], 32'sh72);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      lx_flen   = $urandom_range(6, 12);
      bus.wr    = ($urandom_range(0, 99) < 30);
      bus.din   = 10'($urandom_range(0, 1023));
      bus.clear = ($urandom_range(0, 99) == 0);
      bus.setn  = ($urandom_range(0, 15) != 0);
      tick();
    end
    bus.wr = 1'b0; bus.clear = 1'b0; bus.setn = 1'b1;
    wait_drain("rand_drain");
    chk("rand_all_received", launched.size(), 0);

    // lstx never reacts: watchdog behaviour
    set_mode(2);
    write_word(10'sh0AB);
    tick();
    chk("t6_st_launch", bus.st, 1);
    repeat (14) tick();
    chk("t6_st_l14", bus.st, 1);
    tick();
`ifdef LSTX_FIFO_WDOG_EN
    chk("t6_st_idle", bus.st, 0);
    chk("t6_werr", bus.werr, 1);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("t6_werr_clr", bus.werr, 0);
`else
    repeat (10) tick();
    chk("t6_st_stuck", bus.st, 1);
    chk("t6_werr_zero", bus.werr, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end
endmodule

// File: doc/lstx_fifo.md
# lstx_fifo

Transmit-side word buffer that sits directly upstream of the `lstx` serialiser. It accepts signed words from the host on a single-cycle write strobe and stores them in a circular FIFO. It launches each word into `lstx` using the toggle-style `push` handshake, only while `lstx` reports `empty`, and it tracks the serialiser's busy/idle cycle so that exactly one word is in flight at a time.

## Interface
Parameters:
- `DMSB`, 9: data word MSB; must match the `lstx` `DMSB`.
- `AMSB`, 3: FIFO address MSB; depth is 2^(AMSB+1), 16 by default.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `setn`  in  1  synchronous enable; 0 freezes every register.
- `wr`  in  1  write strobe; one word per cycle while high.
- `din`  in  DMSB+1  signed write data, sampled when `wr`=1.
- `clear`  in  1  synchronous flush of stored words.
- `full`  out  1  count == depth.
- `fempty`  out  1  count == 0.
- `count`  out  AMSB+2  number of stored words.
- `ovf`  out  1  sticky flag; a write was attempted while `full`.
- `werr`  out  1  sticky flag; watchdog timeout (see Configuration).
- `busy`  out  1  state != IDLE.
- `st`  out  2  FSM state.
- `tx_empty`  in  1  from `lstx` `empty`.
- `tx_push`  out  1  toggle output to `lstx` `push`.
- `tx_wdata`  out  DMSB+1  to `lstx` `wdata`; registered.

## Operation
- Reset (`rst`=1, asynchronous) sets every register to 0:
  - `wptr`, `rptr`, `count`, `ovf`, `werr`, `tx_push`, `tx_wdata` are 0.
  - `st` is IDLE.
  - Consequently `fempty`=1, `full`=0, `busy`=0.
  - Memory contents are don't-care.
- All updates below require `setn`=1. With `setn`=0 every register holds its value.
- Write path:
  - When `wr` is high and not `full`: `mem[wptr]` <= `din`, `wptr`++ (wraps modulo depth), `count`++.
  - When `wr` is high and `full`: the word is dropped and `ovf` is set.
- Pop: `rptr`++ (wraps), `count`--.
  - A write and a pop in the same cycle both take effect, so `count` is unchanged.
  - A pop of the word being written in the same cycle cannot occur, because the pop tests the registered `count`.
- `clear`:
  - Sets `wptr`=`rptr`=`count`=0 and clears `ovf` and `werr`.
  - It has priority over `wr` and pop in the same cycle.
  - It does not change `st`, `tx_push` or `tx_wdata`; an in-flight word completes.
- FSM states (encoding): IDLE=00, BUSY=01, DONE=10; 11 is illegal and goes to IDLE.
  - IDLE: if `count`!=0, `tx_empty`=1 and no `clear`, launch:
    - `tx_wdata` <= `mem[rptr]`
    - `tx_push` <= ~`tx_push`
    - pop
    - `st` -> BUSY
  - BUSY: wait for `lstx` to accept. If `tx_empty`=0, `st` -> DONE.
  - DONE: wait for serialisation to end. If `tx_empty`=1, `st` -> IDLE.
- `tx_wdata` holds its value from launch until the next launch. This satisfies the `lstx` requirement that `wdata` be stable while its `push` edge is detected.

## Timing
- Write-to-launch latency is 2 edges:
  - `wr` sampled at edge E0 gives `count`=1 after E0.
  - The launch happens at E1: `tx_push` toggles and `tx_wdata` is valid after E1.
- BUSY lasts until `lstx` reacts to the push edge, typically 2–3 cycles.
- DONE lasts for the whole serial frame.
- Back-to-back words: the next launch occurs on the first edge after the cycle in which `st`=IDLE with `tx_empty`=1. Minimum spacing between launches is 3 edges plus the `lstx` frame time.
- `full`, `fempty`, `count` and `busy` are decoded from registers; they have no combinational path from inputs.
- A `rst` assertion mid-frame returns the FSM to IDLE and leaves `tx_push`=0. This may present a toggle to `lstx`; the integrator resets both blocks together.

## Configuration
- `LSTX_FIFO_WDOG_EN` defined:
  - A 4-bit counter runs in BUSY and clears on entry to BUSY.
  - If it reaches 15 while `tx_empty` is still 1: `werr` is set, `st` -> IDLE, and the popped word is lost.
  - The counter holds when `setn`=0.
- `LSTX_FIFO_WDOG_EN` undefined:
  - There is no counter.
  - `werr` is tied to 0.
  - BUSY waits indefinitely.

## Test plan
- Reset, then write 0x155 with `tx_empty`=1:
  - `count`=1 after E0.
  - `tx_push` toggles 0->1 and `tx_wdata`=0x155 after E1.
  - `st`=BUSY.
- Write 16 words 0..15, then one more:
  - `full`=1, `ovf`=1, `count`=16.
  - The model's `lstx` receives 0..15 in order, with `tx_push` toggling 16 times.
- Write and launch in the same cycle with `count`=3:
  - `count` stays 3.
  - `wptr` and `rptr` both advance, including the wrap from 15 to 0.
- `clear` while in DONE with 5 words stored:
  - `count`=0 and `fempty`=1.
  - The in-flight frame completes, `st` returns to IDLE, and there are no further toggles.
- Hold `setn`=0 for 10 cycles mid-BUSY while toggling `wr`:
  - No register changes.
  - Operation resumes unchanged when `setn`=1.
- With `LSTX_FIFO_WDOG_EN`, hold `tx_empty`=1 after a launch:
  - `werr`=1 and `st`=IDLE 15 cycles after entry to BUSY.
  - Without the macro, `st` stays BUSY and `werr`=0.
